fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Reader/drain side of the 8-bit FIFO.
- Pops bytes from the FIFO's show-ahead read port.
- Serializes each byte onto a single UART-style line: 8N1, LSB first.
- Sits between the FIFO and the pad/debug TX pin; the FIFO's writer side stays unchanged.

Parameters:
- DATA_W, 8, width of the FIFO word and of the serialized payload.
- CLK_DIV, 4, clk cycles per bit; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_data  input  DATA_W  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_empty  input  1  FIFO has no entries.
- fifo_pop  output  1  one-cycle pulse; consumes the head word on this clk edge.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Reset is asynchronous and active-low. Clock is clk; the reset port is rst_n.
- Reset values: tx=1, fifo_pop=0, busy=0, frame_done=0, state=IDLE, bit counter=0, divider=0.
- Assertion of rst_n mid-frame forces tx high immediately, with no clock needed. The in-flight byte is discarded and the FIFO is not re-popped.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If fifo_empty=0, drive fifo_pop=1 combinationally for that cycle.
  - Latch fifo_data into the shift register and go to START.
  - If fifo_empty=1, stay in IDLE with tx=1.
- START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLK_DIV cycles, then shift right.
  - After DATA_W bits, go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - frame_done=1 in the final cycle.
  - In that same final cycle, if fifo_empty=0: assert fifo_pop, latch fifo_data, go straight to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Frame length: exactly (DATA_W+2)*CLK_DIV cycles from the first tx=0 cycle to the end of the stop bit.
- Latency: the first start-bit cycle is the cycle after the pop cycle.
- busy=1 from the cycle after the pop through the last stop cycle. During back-to-back frames busy stays high continuously.
- fifo_pop is never asserted when fifo_empty=1. There is at most one pop per frame.
- Divider counter width: $clog2(CLK_DIV+1), minimum 1 bit. Bit index width: $clog2(DATA_W+1).
- CLK_DIV=1 must work: each bit lasts one cycle.
- fifo_data changing while not popping is ignored; the shift register is the only payload source.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP);
  - localparams for the idle line level (1) and start level (0).
- One sub-module, uart_bit_timer:
  - divider counter producing a bit_end strobe every CLK_DIV cycles;
  - restartable by a load pulse;
  - rst_n async.
- The FSM and shift register stay in fifo_uart_tx.

Test Plan:
- Reset then fifo_empty=1 for 50 cycles -> tx=1, fifo_pop=0, busy=0 throughout.
- CLK_DIV=4, one byte 0x55 -> exactly one fifo_pop pulse. tx then shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total). frame_done pulses once at cycle 40. busy then drops.
- CLK_DIV=4, FIFO holds 0x01,0x02 -> pops in cycle 0 and cycle 40. The second start bit immediately follows the first stop bit. Decoded bytes are 0x01 then 0x02. busy stays high for 80 cycles.
- rst_n pulled low at cycle 13 of a 0xA3 frame -> tx=1 asynchronously, busy=0, no extra pop. After release with the FIFO still non-empty, the next byte is sent as a complete frame.
- CLK_DIV=1, byte 0xF0 -> 10-cycle frame: tx = 0,0,0,0,0,1,1,1,1,1.
- fifo_empty asserted and deasserted on the exact STOP final cycle -> a pop occurs only if fifo_empty=0 in that cycle. Never pop while empty; assertion checked for the whole run.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: bit_end strobes on the last clk of every CLK_DIV-cycle bit.
module uart_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic bit_end
);

  localparam int unsigned CW = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // load holds the count at zero so the first bit after a restart is a full period
  always_comb begin
    bit_end = 1'b0;
    cnt_d   = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      bit_end = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serializes each byte as 8N1, LSB first.
module fifo_uart_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  import fifo_uart_pkg::*;

  localparam int unsigned IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              bit_end;
  logic              pop_req;
  logic              timer_load;

  assign timer_load = (state_q == IDLE);

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    pop_req    = 1'b0;
    frame_done = 1'b0;
    tx         = LINE_IDLE;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          shift_d = fifo_data;
          state_d = START;
        end
      end
      START: begin
        tx = LINE_START;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          if (!fifo_empty) begin
            pop_req = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE with a non-empty FIFO would otherwise pop while reset is held
  assign fifo_pop = pop_req & rst_n;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two DUTs (CLK_DIV=4 and CLK_DIV=1) fed from queue-model FIFOs.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fdata0, fdata1;
  logic [1:0] fempty_v;
  logic [1:0] fpopv, txv, busyv, fdonev;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata0), .fifo_empty(fempty_v[0]),
    .fifo_pop(fpopv[0]), .tx(txv[0]), .busy(busyv[0]), .frame_done(fdonev[0])
  );

  fifo_uart_tx #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fdata1), .fifo_empty(fempty_v[1]),
    .fifo_pop(fpopv[1]), .tx(txv[1]), .busy(busyv[1]), .frame_done(fdonev[1])
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q0[$], q1[$];
  logic [7:0]  eq0[$], eq1[$];
  logic [1:0]  force_empty = '0;
  logic [1:0]  pop_s = '0;
  logic        act [2];
  int unsigned mcnt [2];
  logic [9:0]  mframe [2];
  logic [7:0]  mexp [2];
  logic [7:0]  rxb [2];
  logic        prevpop [2];
  int unsigned start_t [2];
  int unsigned prev_start_t [2];
  int unsigned fd_cnt [2];
  int unsigned pops [2];
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic refresh();
    fempty_v[0] = (q0.size() == 0) || force_empty[0];
    fempty_v[1] = (q1.size() == 0) || force_empty[1];
    fdata0 = 8'hEE;
    fdata1 = 8'hEE;
    if (q0.size() != 0) fdata0 = q0[0];
    if (q1.size() != 0) fdata1 = q1[0];
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    if (ch == 0) begin q0.push_back(b); eq0.push_back(b); end
    else         begin q1.push_back(b); eq1.push_back(b); end
    refresh();
  endtask

  // FIFO model: the head advances just after an edge on which a pop was presented
  initial begin
    logic [7:0] tmp;
    forever begin
      @(posedge clk);
      #1;
      if (pop_s[0] && q0.size() != 0) tmp = q0.pop_front();
      if (pop_s[1] && q1.size() != 0) tmp = q1.pop_front();
      refresh();
    end
  end

  task automatic mon_step(input int ch);
    int unsigned d, bitn;
    logic t, b, fd, p, e;
    d  = (ch == 0) ? 4 : 1;
    t  = txv[ch];
    b  = busyv[ch];
    fd = fdonev[ch];
    p  = fpopv[ch];
    e  = fempty_v[ch];
    pop_s[ch] = p;
    if (!rst_n) begin
      act[ch]     = 1'b0;
      prevpop[ch] = 1'b0;
      chk($sformatf("rst_tx%0d", ch), t, 1);
      chk($sformatf("rst_busy%0d", ch), b, 0);
      chk($sformatf("rst_pop%0d", ch), p, 0);
      return;
    end
    chk($sformatf("pop_when_empty%0d", ch), p & e, 0);
    if (p) pops[ch]++;
    if (fd) fd_cnt[ch]++;
    if (!act[ch] && t == 1'b0) begin
      mexp[ch] = 8'h00;
      if ((ch == 0 ? eq0.size() : eq1.size()) == 0) chk($sformatf("unexpected_frame%0d", ch), 1, 0);
      else if (ch == 0) mexp[ch] = eq0.pop_front();
      else              mexp[ch] = eq1.pop_front();
      mframe[ch] = {1'b1, mexp[ch], 1'b0};
      chk($sformatf("pop_latency%0d", ch), prevpop[ch], 1);
      prev_start_t[ch] = start_t[ch];
      start_t[ch]      = cyc;
      act[ch]          = 1'b1;
      mcnt[ch]         = 0;
    end
    if (act[ch]) begin
      bitn = mcnt[ch] / d;
      chk($sformatf("tx_bit%0d_c%0d", ch, mcnt[ch]), t, mframe[ch][bitn]);
      chk($sformatf("busy_frame%0d", ch), b, 1);
      chk($sformatf("frame_done_pos%0d", ch), fd, (mcnt[ch] == 10 * d - 1));
      if (bitn >= 1 && bitn <= 8 && (mcnt[ch] % d) == d / 2) rxb[ch][bitn-1] = t;
      mcnt[ch]++;
      if (mcnt[ch] == 10 * d) begin
        act[ch] = 1'b0;
        chk($sformatf("rx_byte%0d", ch), rxb[ch], mexp[ch]);
      end
    end else begin
      chk($sformatf("idle_busy%0d", ch), b, 0);
      chk($sformatf("idle_frame_done%0d", ch), fd, 0);
    end
    prevpop[ch] = p;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int ch = 0; ch < 2; ch++) mon_step(ch);
  end

  task automatic wait_pop(input int ch);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fpopv[ch] && n < 200);
    if (!fpopv[ch]) chk($sformatf("wait_pop_timeout%0d", ch), 1, 0);
  endtask

  task automatic drain(input int ch);
    int unsigned n;
    n = 0;
    while (n < 3000 && !(((ch == 0) ? q0.size() : q1.size()) == 0 && !act[ch] && !busyv[ch])) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk($sformatf("drain_timeout%0d", ch), 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int unsigned p0, f0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; mcnt[i] = 0; mframe[i] = '1; mexp[i] = '0; rxb[i] = '0;
      prevpop[i] = 1'b0; start_t[i] = 0; prev_start_t[i] = 0; fd_cnt[i] = 0; pops[i] = 0;
    end
    rst_n = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // idle with an empty FIFO
    repeat (50) @(posedge clk);
    chk("idle_no_pop", pops[0], 0);

    // single byte 0x55
    @(posedge clk); #2;
    p0 = pops[0]; f0 = fd_cnt[0];
    push(0, 8'h55);
    drain(0);
    chk("single_pop_count", pops[0] - p0, 1);
    chk("single_frame_done_count", fd_cnt[0] - f0, 1);

    // back-to-back 0x01, 0x02
    @(posedge clk); #2;
    p0 = pops[0]; f0 = fd_cnt[0];
    push(0, 8'h01);
    push(0, 8'h02);
    drain(0);
    chk("b2b_pop_count", pops[0] - p0, 2);
    chk("b2b_frame_done_count", fd_cnt[0] - f0, 2);
    chk("b2b_start_gap", start_t[0] - prev_start_t[0], 40);

    // async reset mid-frame of 0xA3; 0x5C must follow as a whole frame
    @(posedge clk); #2;
    p0 = pops[0]; f0 = fd_cnt[0];
    push(0, 8'hA3);
    push(0, 8'h5C);
    wait_pop(0);
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", txv[0], 1);
    chk("async_rst_busy", busyv[0], 0);
    chk("async_rst_pop", fpopv[0], 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drain(0);
    chk("rst_pop_count", pops[0] - p0, 2);
    chk("rst_frame_done_count", fd_cnt[0] - f0, 1);

    // CLK_DIV=1, byte 0xF0
    @(posedge clk); #2;
    p0 = pops[1]; f0 = fd_cnt[1];
    push(1, 8'hF0);
    drain(1);
    chk("div1_pop_count", pops[1] - p0, 1);
    chk("div1_frame_done_count", fd_cnt[1] - f0, 1);

    // FIFO reads empty only on the final stop cycle: no pop there, one idle cycle
    @(posedge clk); #2;
    push(0, 8'h3C);
    wait_pop(0);
    @(posedge clk); #2;
    push(0, 8'h99);
    repeat (39) @(posedge clk);
    #2 force_empty[0] = 1'b1;
    refresh();
    @(negedge clk);
    chk("forced_empty_final_pop", fpopv[0], 0);
    chk("forced_empty_final_done", fdonev[0], 1);
    @(posedge clk); #2 force_empty[0] = 1'b0;
    refresh();
    drain(0);
    chk("forced_empty_start_gap", start_t[0] - prev_start_t[0], 41);

    // FIFO becomes non-empty exactly on the final stop cycle: back-to-back pop
    @(posedge clk); #2;
    push(0, 8'h81);
    wait_pop(0);
    repeat (40) @(posedge clk);
    #2 push(0, 8'h7E);
    @(negedge clk);
    chk("late_fill_final_pop", fpopv[0], 1);
    chk("late_fill_final_done", fdonev[0], 1);
    drain(0);
    chk("late_fill_start_gap", start_t[0] - prev_start_t[0], 40);
    chk("scoreboard_empty0", eq0.size(), 0);
    chk("scoreboard_empty1", eq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
